// File: rtl/ahblite_master_mux.sv
// ahblite_master_mux: shares one AHB-Lite interconnect port between two masters
// (port 0 = CPU, port 1 = DMA / boot loader). A master that loses arbitration has
// its address phase parked in a per-port hold register and is stalled through its
// HREADY until the parked transfer has been issued. Data-phase responses go back to
// the port that owns the data phase.
// Optional feature macro: MASTER_MUX_LOCK_EN (locked transfers pin the grant and
// HMASTLOCK is forwarded); without it HMASTLOCK_Sx is ignored and HMASTLOCK_M is 0.
module ahblite_master_mux (
    input  logic        HCLK,
    input  logic        HRESETn,
    // port 0 (CPU)
    input  logic [31:0] HADDR_S0,
    input  logic [1:0]  HTRANS_S0,
    input  logic [2:0]  HSIZE_S0,
    input  logic [2:0]  HBURST_S0,
    input  logic [3:0]  HPROT_S0,
    input  logic        HWRITE_S0,
    input  logic        HMASTLOCK_S0,
    input  logic [31:0] HWDATA_S0,
    output logic [31:0] HRDATA_S0,
    output logic        HREADY_S0,
    output logic        HRESP_S0,
    // port 1 (second master)
    input  logic [31:0] HADDR_S1,
    input  logic [1:0]  HTRANS_S1,
    input  logic [2:0]  HSIZE_S1,
    input  logic [2:0]  HBURST_S1,
    input  logic [3:0]  HPROT_S1,
    input  logic        HWRITE_S1,
    input  logic        HMASTLOCK_S1,
    input  logic [31:0] HWDATA_S1,
    output logic [31:0] HRDATA_S1,
    output logic        HREADY_S1,
    output logic        HRESP_S1,
    // interconnect side
    output logic [31:0] HADDR_M,
    output logic [1:0]  HTRANS_M,
    output logic [2:0]  HSIZE_M,
    output logic [2:0]  HBURST_M,
    output logic [3:0]  HPROT_M,
    output logic        HWRITE_M,
    output logic        HMASTLOCK_M,
    output logic [31:0] HWDATA_M,
    input  logic [31:0] HRDATA_M,
    input  logic        HREADY_M,
    input  logic        HRESP_M
);

    // live per-port signals gathered into arrays so port logic can be generated
    logic [31:0] w_addr  [2];
    logic [1:0]  w_trans [2];
    logic [2:0]  w_size  [2];
    logic [2:0]  w_burst [2];
    logic [3:0]  w_prot  [2];
    logic        w_write [2];
    logic [31:0] w_wdata [2];

    assign w_addr[0]  = HADDR_S0;   assign w_addr[1]  = HADDR_S1;
    assign w_trans[0] = HTRANS_S0;  assign w_trans[1] = HTRANS_S1;
    assign w_size[0]  = HSIZE_S0;   assign w_size[1]  = HSIZE_S1;
    assign w_burst[0] = HBURST_S0;  assign w_burst[1] = HBURST_S1;
    assign w_prot[0]  = HPROT_S0;   assign w_prot[1]  = HPROT_S1;
    assign w_write[0] = HWRITE_S0;  assign w_write[1] = HWRITE_S1;
    assign w_wdata[0] = HWDATA_S0;  assign w_wdata[1] = HWDATA_S1;

    // arbitration / data-phase state
    logic        r_grant;
    logic        r_last;
    logic [1:0]  r_pend;
    logic        r_dvalid;
    logic        r_downer;

    // parked address phase per port
    logic [31:0] r_addr  [2];
    logic [1:0]  r_trans [2];
    logic [2:0]  r_size  [2];
    logic [2:0]  r_burst [2];
    logic [3:0]  r_prot  [2];
    logic        r_write [2];

    // forwarded address phase
    logic [31:0] w_fwd_addr;
    logic [1:0]  w_fwd_trans;
    logic [2:0]  w_fwd_size;
    logic [2:0]  w_fwd_burst;
    logic [3:0]  w_fwd_prot;
    logic        w_fwd_write;

    logic        w_issue;
    logic [1:0]  w_own_dp;
    logic [1:0]  w_hready_s;
    logic [1:0]  w_hresp_s;
    logic [1:0]  w_live_issue;
    logic [1:0]  w_capture;
    logic [1:0]  w_hold_issue;
    logic [1:0]  w_pend_next;
    logic        w_last_next;
    logic        w_lock_next;
    logic        w_grant_next;

    // granted port drives the bus: its parked transfer first, else its live signals
    always_comb begin
        if (r_pend[r_grant]) begin
            w_fwd_addr  = r_addr[r_grant];
            w_fwd_trans = r_trans[r_grant];
            w_fwd_size  = r_size[r_grant];
            w_fwd_burst = r_burst[r_grant];
            w_fwd_prot  = r_prot[r_grant];
            w_fwd_write = r_write[r_grant];
        end else begin
            w_fwd_addr  = w_addr[r_grant];
            w_fwd_trans = w_trans[r_grant];
            w_fwd_size  = w_size[r_grant];
            w_fwd_burst = w_burst[r_grant];
            w_fwd_prot  = w_prot[r_grant];
            w_fwd_write = w_write[r_grant];
        end
    end

    assign w_issue = w_fwd_trans[1] & HREADY_M;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            // this port owns the outstanding data phase on the interconnect
            assign w_own_dp[gi]     = r_dvalid && (r_downer == 1'(gi));
            // owner follows the slave; a parked port stalls; everyone else is free
            assign w_hready_s[gi]   = w_own_dp[gi] ? HREADY_M : ~r_pend[gi];
            assign w_hresp_s[gi]    = w_own_dp[gi] ? HRESP_M : 1'b0;
            // live address phase accepted by the interconnect this cycle
            assign w_live_issue[gi] = (r_grant == 1'(gi)) && !r_pend[gi] && HREADY_M;
            // master believes its address phase was taken but the bus did not take it
            assign w_capture[gi]    = w_hready_s[gi] && w_trans[gi][1] && !w_live_issue[gi];
            assign w_hold_issue[gi] = (r_grant == 1'(gi)) && r_pend[gi] && w_issue;
            assign w_pend_next[gi]  = w_capture[gi] | (r_pend[gi] & ~w_hold_issue[gi]);
        end
    endgenerate

    assign w_last_next = w_issue ? r_grant : r_last;

`ifdef MASTER_MUX_LOCK_EN
    logic r_lock [2];
    logic r_lockhold;
    logic w_fwd_lock;

    assign w_fwd_lock  = r_pend[r_grant] ? r_lock[r_grant]
                                         : (r_grant ? HMASTLOCK_S1 : HMASTLOCK_S0);
    assign w_lock_next = w_issue ? w_fwd_lock : r_lockhold;
    assign HMASTLOCK_M = w_fwd_lock;

    // lock state: parked lock bits and the lock of the last issued transfer
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_lock[0]  <= 1'b0;
            r_lock[1]  <= 1'b0;
            r_lockhold <= 1'b0;
        end else begin
            if (w_capture[0]) r_lock[0] <= HMASTLOCK_S0;
            if (w_capture[1]) r_lock[1] <= HMASTLOCK_S1;
            r_lockhold <= w_lock_next;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = HMASTLOCK_S0 ^ HMASTLOCK_S1;
    assign w_lock_next   = 1'b0;
    assign HMASTLOCK_M   = 1'b0;
`endif

    // next owner of the address phase, decided on next-cycle requests
    always_comb begin
        w_grant_next = r_grant;
        if (HREADY_M && !w_lock_next && !w_trans[r_grant][0]) begin
            case (w_pend_next)
                2'b01:   w_grant_next = 1'b0;
                2'b10:   w_grant_next = 1'b1;
                2'b11:   w_grant_next = ~w_last_next;
                default: w_grant_next = 1'b0;
            endcase
        end
    end

    // arbitration, parked-request flags and data-phase ownership
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_grant  <= 1'b0;
            r_last   <= 1'b1;
            r_pend   <= 2'b00;
            r_dvalid <= 1'b0;
            r_downer <= 1'b0;
        end else begin
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
            r_pend  <= w_pend_next;
            if (HREADY_M) begin
                r_dvalid <= w_fwd_trans[1];
                r_downer <= r_grant;
            end
        end
    end

    // load the hold registers whenever a port's address phase is parked
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 2; i++) begin
                r_addr[i]  <= '0;
                r_trans[i] <= '0;
                r_size[i]  <= '0;
                r_burst[i] <= '0;
                r_prot[i]  <= '0;
                r_write[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_capture[i]) begin
                    r_addr[i]  <= w_addr[i];
                    r_trans[i] <= w_trans[i];
                    r_size[i]  <= w_size[i];
                    r_burst[i] <= w_burst[i];
                    r_prot[i]  <= w_prot[i];
                    r_write[i] <= w_write[i];
                end
            end
        end
    end

    assign HADDR_M   = w_fwd_addr;
    assign HTRANS_M  = w_fwd_trans;
    assign HSIZE_M   = w_fwd_size;
    assign HBURST_M  = w_fwd_burst;
    assign HPROT_M   = w_fwd_prot;
    assign HWRITE_M  = w_fwd_write;
    assign HWDATA_M  = w_wdata[r_downer];

    assign HRDATA_S0 = HRDATA_M;
    assign HRDATA_S1 = HRDATA_M;
    assign HREADY_S0 = w_hready_s[0];
    assign HREADY_S1 = w_hready_s[1];
    assign HRESP_S0  = w_hresp_s[0];
    assign HRESP_S1  = w_hresp_s[1];

endmodule

// File: tb/tb_ahblite_master_mux.sv
// Bench for ahblite_master_mux: directed scenarios followed by randomized traffic
// from two AHB-Lite master models, checked by a transaction scoreboard.
module tb_ahblite_master_mux;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] s_addr  [2];
    logic [1:0]  s_trans [2];
    logic [2:0]  s_size  [2];
    logic [2:0]  s_burst [2];
    logic [3:0]  s_prot  [2];
    logic        s_write [2];
    logic        s_lock  [2];
    logic [31:0] s_wdata [2];
    logic [31:0] HRDATA_S0, HRDATA_S1;
    logic        HREADY_S0, HREADY_S1, HRESP_S0, HRESP_S1;
    logic [31:0] HADDR_M, HWDATA_M, HRDATA_M;
    logic [1:0]  HTRANS_M;
    logic [2:0]  HSIZE_M, HBURST_M;
    logic [3:0]  HPROT_M;
    logic        HWRITE_M, HMASTLOCK_M, HREADY_M, HRESP_M;

    ahblite_master_mux dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HADDR_S0(s_addr[0]), .HTRANS_S0(s_trans[0]), .HSIZE_S0(s_size[0]),
        .HBURST_S0(s_burst[0]), .HPROT_S0(s_prot[0]), .HWRITE_S0(s_write[0]),
        .HMASTLOCK_S0(s_lock[0]), .HWDATA_S0(s_wdata[0]),
        .HRDATA_S0(HRDATA_S0), .HREADY_S0(HREADY_S0), .HRESP_S0(HRESP_S0),
        .HADDR_S1(s_addr[1]), .HTRANS_S1(s_trans[1]), .HSIZE_S1(s_size[1]),
        .HBURST_S1(s_burst[1]), .HPROT_S1(s_prot[1]), .HWRITE_S1(s_write[1]),
        .HMASTLOCK_S1(s_lock[1]), .HWDATA_S1(s_wdata[1]),
        .HRDATA_S1(HRDATA_S1), .HREADY_S1(HREADY_S1), .HRESP_S1(HRESP_S1),
        .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M), .HSIZE_M(HSIZE_M), .HBURST_M(HBURST_M),
        .HPROT_M(HPROT_M), .HWRITE_M(HWRITE_M), .HMASTLOCK_M(HMASTLOCK_M),
        .HWDATA_M(HWDATA_M), .HRDATA_M(HRDATA_M), .HREADY_M(HREADY_M), .HRESP_M(HRESP_M)
    );

    always #5 HCLK = ~HCLK;

    logic        hready_s [2];
    logic        hresp_s  [2];
    logic [31:0] hrdata_s [2];
    assign hready_s[0] = HREADY_S0;  assign hready_s[1] = HREADY_S1;
    assign hresp_s[0]  = HRESP_S0;   assign hresp_s[1]  = HRESP_S1;
    assign hrdata_s[0] = HRDATA_S0;  assign hrdata_s[1] = HRDATA_S1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge HCLK);
        #1;
    endtask

    // ---------------- scoreboard / master models ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
    } xfer_t;

    xfer_t       q0[$];
    xfer_t       q1[$];
    int          order[$];
    logic        dp_valid [2];      // master-side outstanding data phase
    logic [31:0] dp_addr  [2];
    logic        m_dp_valid;        // interconnect-side outstanding data phase
    logic [31:0] m_dp_addr;
    int          seq = 0;

    // write data is a function of the address so the data-phase owner is visible
    function automatic logic [31:0] wfun(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // port number is encoded in address bit 12
    task automatic new_req(input int p, input int pn);
        if (int'($urandom_range(99)) < pn) begin
            s_trans[p] = 2'b10;
            s_addr[p]  = 32'h2000_0000 | (32'(p) << 12) | (32'(seq & 1023) << 2);
            s_write[p] = 1'($urandom_range(1));
            s_size[p]  = 3'd2;
            s_burst[p] = 3'd0;
            s_prot[p]  = 4'($urandom_range(15));
            seq++;
        end else begin
            s_trans[p] = 2'b00;
        end
    endtask

    task automatic sb_cycle(input int pn, input int phm);
        logic  rdy [2];
        logic  done;
        int    port;
        xfer_t x;
        @(negedge HCLK);
        rdy[0] = HREADY_S0;
        rdy[1] = HREADY_S1;
        for (int p = 0; p < 2; p++) begin
            if (!dp_valid[p]) begin
                chk("hready_idle", 32'(rdy[p]), 32'd1);
            end else begin
                done = m_dp_valid && (int'(m_dp_addr[12]) == p) && HREADY_M;
                chk("hready_dp", 32'(rdy[p]), 32'(done));
                if (done) chk("dp_addr", m_dp_addr, dp_addr[p]);
            end
            chk("hresp", 32'(hresp_s[p]),
                (m_dp_valid && int'(m_dp_addr[12]) == p) ? 32'(HRESP_M) : 32'd0);
            chk("hrdata", hrdata_s[p], HRDATA_M);
            if (rdy[p] && s_trans[p][1]) begin
                x = '{addr: s_addr[p], write: s_write[p], size: s_size[p],
                      burst: s_burst[p], prot: s_prot[p]};
                if (p == 0) q0.push_back(x); else q1.push_back(x);
            end
        end
        if (m_dp_valid) chk("hwdata", HWDATA_M, wfun(m_dp_addr));
        chk("hmastlock_m", 32'(HMASTLOCK_M), 32'd0);
        if (HREADY_M && HTRANS_M[1]) begin
            port = int'(HADDR_M[12]);
            order.push_back(port);
            $display("xfer port %0d addr %h write %0d", port, HADDR_M, HWRITE_M);
            chk("issue_known", 32'(port == 0 ? q0.size() > 0 : q1.size() > 0), 32'd1);
            if (port == 0 && q0.size() > 0) x = q0.pop_front();
            else if (port == 1 && q1.size() > 0) x = q1.pop_front();
            else x = '0;
            chk("issue_addr", HADDR_M, x.addr);
            chk("issue_ctl", {21'd0, HWRITE_M, HSIZE_M, HBURST_M, HPROT_M},
                {21'd0, x.write, x.size, x.burst, x.prot});
        end
        if (HREADY_M) begin
            m_dp_valid = HTRANS_M[1];
            m_dp_addr  = HADDR_M;
        end
        next_cycle();
        for (int p = 0; p < 2; p++) begin
            if (rdy[p]) begin
                dp_valid[p] = s_trans[p][1];
                if (s_trans[p][1]) dp_addr[p] = s_addr[p];
                s_wdata[p] = wfun(dp_addr[p]);
                new_req(p, pn);
            end
        end
        HREADY_M = (int'($urandom_range(99)) < phm);
        HRESP_M  = ($urandom_range(9) == 0);
        HRDATA_M = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) sb_cycle(0, 100);
        chk("drain_q0", q0.size(), 32'd0);
        chk("drain_q1", q1.size(), 32'd0);
        chk("drain_dp0", 32'(dp_valid[0]), 32'd0);
        chk("drain_dp1", 32'(dp_valid[1]), 32'd0);
    endtask

    initial begin
        HRESETn  = 1'b0;
        HREADY_M = 1'b1;
        HRESP_M  = 1'b0;
        HRDATA_M = '0;
        for (int p = 0; p < 2; p++) begin
            s_addr[p] = '0; s_trans[p] = '0; s_size[p] = 3'd2; s_burst[p] = '0;
            s_prot[p] = '0; s_write[p] = 1'b0; s_lock[p] = 1'b0; s_wdata[p] = '0;
            dp_valid[p] = 1'b0; dp_addr[p] = '0;
        end
        m_dp_valid = 1'b0;
        m_dp_addr  = '0;

        // reset state: ports ready, no error, bus follows the CPU
        s_trans[0] = 2'b10;
        s_addr[0]  = 32'h3000_0000;
        #2;
        chk("rst_hready_s0", 32'(HREADY_S0), 32'd1);
        chk("rst_hready_s1", 32'(HREADY_S1), 32'd1);
        chk("rst_hresp_s0", 32'(HRESP_S0), 32'd0);
        chk("rst_hresp_s1", 32'(HRESP_S1), 32'd0);
        chk("rst_htrans_m", 32'(HTRANS_M), 32'd2);
        chk("rst_haddr_m", HADDR_M, 32'h3000_0000);
        s_trans[0] = 2'b00;
        @(negedge HCLK);
        HRESETn = 1'b1;
        next_cycle();

        // CPU-only single read
        s_trans[0] = 2'b10; s_addr[0] = 32'h2000_0000; s_write[0] = 1'b0; s_lock[0] = 1'b1;
        HRDATA_M = 32'hA5A5_0001;
        @(negedge HCLK);
        chk("rd_htrans_m", 32'(HTRANS_M), 32'd2);
        chk("rd_haddr_m", HADDR_M, 32'h2000_0000);
`ifdef MASTER_MUX_LOCK_EN
        chk("rd_hmastlock_m", 32'(HMASTLOCK_M), 32'd1);
`else
        chk("rd_hmastlock_m", 32'(HMASTLOCK_M), 32'd0);
`endif
        next_cycle();
        s_trans[0] = 2'b00; s_lock[0] = 1'b0;
        @(negedge HCLK);
        chk("rd_hready_s0", 32'(HREADY_S0), 32'd1);
        chk("rd_hrdata_s0", HRDATA_S0, 32'hA5A5_0001);
        chk("rd_hready_s1", 32'(HREADY_S1), 32'd1);

        // both ports NONSEQ in the same cycle
        next_cycle();
        s_trans[0] = 2'b10; s_addr[0] = 32'h2000_0100;
        s_trans[1] = 2'b10; s_addr[1] = 32'h2000_0010;
        @(negedge HCLK);
        chk("both_haddr_t", HADDR_M, 32'h2000_0100);
        chk("both_hready_s1_t", 32'(HREADY_S1), 32'd1);
        next_cycle();
        s_trans[0] = 2'b00; s_trans[1] = 2'b00;
        @(negedge HCLK);
        chk("both_hready_s1_t1", 32'(HREADY_S1), 32'd0);
        chk("both_haddr_t1", HADDR_M, 32'h2000_0010);
        chk("both_htrans_t1", 32'(HTRANS_M), 32'd2);
        next_cycle();
        @(negedge HCLK);
        chk("both_hready_s1_t2", 32'(HREADY_S1), 32'd1);

        // port 1 write stalled three cycles in its data phase, port 0 parked meanwhile
        next_cycle();
        s_trans[1] = 2'b10; s_addr[1] = 32'h2000_0020; s_write[1] = 1'b1;
        next_cycle();
        s_trans[1] = 2'b00; s_wdata[1] = 32'h1234_5678;
        @(negedge HCLK);
        chk("wr_hready_s1_pend", 32'(HREADY_S1), 32'd0);
        next_cycle();
        HREADY_M = 1'b0;
        s_trans[0] = 2'b10; s_addr[0] = 32'h2000_0200;
        @(negedge HCLK);
        chk("wr_hready_s0_cap", 32'(HREADY_S0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge HCLK);
            chk("wr_hwdata_m", HWDATA_M, 32'h1234_5678);
            chk("wr_hready_s1_stall", 32'(HREADY_S1), 32'd0);
            if (i > 0) chk("wr_hready_s0_stall", 32'(HREADY_S0), 32'd0);
            next_cycle();
            s_trans[0] = 2'b00;
        end
        HREADY_M = 1'b1;
        @(negedge HCLK);
        chk("wr_hready_s1_done", 32'(HREADY_S1), 32'd1);
        chk("wr_hready_s0_issue", 32'(HREADY_S0), 32'd0);
        chk("wr_haddr_m_hold", HADDR_M, 32'h2000_0200);
        chk("wr_htrans_m_hold", 32'(HTRANS_M), 32'd2);
        next_cycle();
        s_wdata[1] = '0;
        @(negedge HCLK);
        chk("wr_hready_s0_done", 32'(HREADY_S0), 32'd1);

        // asynchronous reset with a parked port-1 transfer and a live data phase
        next_cycle();
        s_trans[0] = 2'b10; s_addr[0] = 32'h2000_0300;
        s_trans[1] = 2'b10; s_addr[1] = 32'h2000_0310;
        next_cycle();
        s_trans[0] = 2'b00; s_trans[1] = 2'b00;
        HREADY_M = 1'b0;
        @(negedge HCLK);
        chk("ar_hready_s1_pend", 32'(HREADY_S1), 32'd0);
        chk("ar_hready_s0_dp", 32'(HREADY_S0), 32'd0);
        #1 HRESETn = 1'b0;
        #1;
        chk("ar_hready_s0", 32'(HREADY_S0), 32'd1);
        chk("ar_hready_s1", 32'(HREADY_S1), 32'd1);
        chk("ar_htrans_m", 32'(HTRANS_M), 32'd0);
        next_cycle();
        HRESETn  = 1'b1;
        HREADY_M = 1'b1;
        @(negedge HCLK);
        chk("ar_post_hready_s1", 32'(HREADY_S1), 32'd1);
        chk("ar_post_htrans_m", 32'(HTRANS_M), 32'd0);
        next_cycle();

        // randomized traffic against the scoreboard
        for (int i = 0; i < 400; i++) sb_cycle(60, 70);
        drain();

        // both masters streaming: issue order must alternate 0,1,0,1,...
        order.delete();
        for (int i = 0; i < 12; i++) sb_cycle(100, 100);
        chk("stream_cnt", 32'(order.size() >= 8), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i < order.size()) chk("stream_order", 32'(order[i]), 32'(i % 2));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
